// File: rtl/note_duration_timer_if.sv
// -----------------------------------------------------------------------------
// note_duration_timer_if
//   Valid/ready handshake that carries one {note, duration} pair from the song
//   reader (master) to the note duration timer (slave).
//
//   note_valid  master -> slave  offer is present
//   note_ready  slave  -> master timer can take the offer
//   note_in     master -> slave  note code, 0 = rest
//   dur_in      master -> slave  duration in beats
// -----------------------------------------------------------------------------
interface note_duration_timer_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
);
  logic              note_valid;
  logic              note_ready;
  logic [NOTE_W-1:0] note_in;
  logic [DUR_W-1:0]  dur_in;

  modport master (output note_valid, output note_in, output dur_in, input note_ready);
  modport slave  (input note_valid, input note_in, input dur_in, output note_ready);
endinterface

// File: rtl/note_duration_timer.sv
// -----------------------------------------------------------------------------
// note_duration_timer
//   Accepts a {note, duration} pair from the song reader and drives the note to
//   the note player for exactly `duration` beats of the 48 beats/s tick, then
//   pulses note_done for one cycle so the reader can advance.
//
//   clk          system clock
//   rst          synchronous, active-high reset
//   beat_i       one-cycle beat tick (a tick held k cycles counts k beats)
//   play_i       1 = count beats, 0 = pause (beats dropped, state held)
//   stop_i       abort the current note, back to IDLE without note_done
//   note_bus     slave side of the {note, duration} valid/ready handshake
//   note_out_o   note currently sounding, 0 outside PLAYING
//   remaining_o  beats left on the current note
//   busy_o       high while PLAYING
//   note_done_o  one-cycle pulse when a note completes normally
// -----------------------------------------------------------------------------
module note_duration_timer #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    beat_i,
  input  logic                    play_i,
  input  logic                    stop_i,
  note_duration_timer_if.slave    note_bus,
  output logic [NOTE_W-1:0]       note_out_o,
  output logic [DUR_W-1:0]        remaining_o,
  output logic                    busy_o,
  output logic                    note_done_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e            state_q;
  logic [NOTE_W-1:0] note_q;
  logic [DUR_W-1:0]  remaining_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  // Every output is a flop, so nothing on the input side can ripple through
  // to the note player or the song reader in the same cycle.
  // NOTE: rst is sampled on the clock edge (synchronous); it is not in the
  // sensitivity list, and it is the first branch so it overrides stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: all state uses non-blocking assignments so every flop sees the
      // pre-edge values of the others, independent of statement order.
      state_q     <= ST_IDLE;
      note_q      <= '0;
      remaining_q <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (stop_i) begin
      // Abort wins over beats and over a pending handshake offer.
      state_q     <= ST_IDLE;
      note_q      <= '0;
      remaining_q <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (note_bus.note_valid) begin
            // A beat on the accept edge is not counted: remaining loads raw.
            state_q     <= ST_PLAYING;
            note_q      <= note_bus.note_in;
            remaining_q <= note_bus.dur_in;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        ST_PLAYING: begin
          // Zero-length notes finish on the next edge without waiting on a beat.
          if (remaining_q == '0) begin
            state_q <= ST_DONE;
            note_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (play_i && beat_i) begin
            remaining_q <= remaining_q - DUR_W'(1);
            if (remaining_q == DUR_W'(1)) begin
              state_q <= ST_DONE;
              note_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          // Ready stays low through DONE so a held offer is taken only once
          // per DONE -> IDLE pass.
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end

        default: begin
          state_q     <= ST_IDLE;
          note_q      <= '0;
          remaining_q <= '0;
          ready_q     <= 1'b1;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign note_bus.note_ready = ready_q;
  assign note_out_o          = note_q;
  assign remaining_o         = remaining_q;
  assign busy_o              = busy_q;
  assign note_done_o         = done_q;

endmodule

// File: tb/tb_note_duration_timer.sv
// -----------------------------------------------------------------------------
// tb_note_duration_timer
//   Directed bench for note_duration_timer. Inputs change 1 ns after a rising
//   edge and outputs are read at that same point, so every read sees the
//   state just registered on the preceding edge.
// -----------------------------------------------------------------------------
module tb_note_duration_timer;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  logic              clk;
  logic              rst;
  logic              beat;
  logic              play;
  logic              stop;
  logic [NOTE_W-1:0] note_out;
  logic [DUR_W-1:0]  remaining;
  logic              busy;
  logic              note_done;

  int checks = 0;
  int errors = 0;

  note_duration_timer_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

  note_duration_timer #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .beat_i      (beat),
    .play_i      (play),
    .stop_i      (stop),
    .note_bus    (bus.slave),
    .note_out_o  (note_out),
    .remaining_o (remaining),
    .busy_o      (busy),
    .note_done_o (note_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one note for exactly one edge (block must be IDLE).
  task automatic offer(input logic [NOTE_W-1:0] n, input logic [DUR_W-1:0] d);
    bus.note_valid = 1'b1;
    bus.note_in    = n;
    bus.dur_in     = d;
    tick();
    bus.note_valid = 1'b0;
    bus.note_in    = '0;
    bus.dur_in     = '0;
  endtask

  task automatic beat_pulse();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  // Compare the full observable output set against expected values.
  task automatic expect_outputs(input string name, input logic rdy, input logic bsy,
                                input logic [NOTE_W-1:0] nt, input logic [DUR_W-1:0] rem,
                                input logic dn);
    checks++;
    if ({bus.note_ready, busy, note_out, remaining, note_done} !== {rdy, bsy, nt, rem, dn}) begin
      errors++;
      $display("FAIL %s: got ready=%0b busy=%0b note=%0d rem=%0d done=%0b, want ready=%0b busy=%0b note=%0d rem=%0d done=%0b",
               name, bus.note_ready, busy, note_out, remaining, note_done, rdy, bsy, nt, rem, dn);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    expect_outputs("reset", 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
    rst = 1'b0;
    tick();
    expect_outputs("reset_release_idle", 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic test_basic();
    play = 1'b1;
    offer(6'd17, 6'd3);
    expect_outputs("basic_accept", 1'b0, 1'b1, 6'd17, 6'd3, 1'b0);
    tick(9);
    expect_outputs("basic_hold_no_beat", 1'b0, 1'b1, 6'd17, 6'd3, 1'b0);
    beat_pulse();
    expect_outputs("basic_beat1", 1'b0, 1'b1, 6'd17, 6'd2, 1'b0);
    tick(9);
    beat_pulse();
    expect_outputs("basic_beat2", 1'b0, 1'b1, 6'd17, 6'd1, 1'b0);
    tick(9);
    beat_pulse();
    expect_outputs("basic_done", 1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
    tick();
    expect_outputs("basic_idle_after", 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic test_zero_dur();
    offer(6'd5, 6'd0);
    expect_outputs("zero_playing", 1'b0, 1'b1, 6'd5, 6'd0, 1'b0);
    tick();
    expect_outputs("zero_done", 1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
    tick();
    expect_outputs("zero_idle", 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic test_pause();
    play = 1'b0;
    offer(6'd22, 6'd2);
    for (int i = 0; i < 5; i++) begin
      tick(2);
      beat_pulse();
    end
    expect_outputs("pause_hold", 1'b0, 1'b1, 6'd22, 6'd2, 1'b0);
    play = 1'b1;
    tick(2);
    beat_pulse();
    expect_outputs("pause_resume_beat1", 1'b0, 1'b1, 6'd22, 6'd1, 1'b0);
    tick(2);
    beat_pulse();
    expect_outputs("pause_resume_done", 1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
    tick();
  endtask

  task automatic test_stop();
    offer(6'd9, 6'd4);
    beat_pulse();
    expect_outputs("stop_before", 1'b0, 1'b1, 6'd9, 6'd3, 1'b0);
    stop = 1'b1;
    beat = 1'b1;                    // stop must win over a coincident beat
    tick();
    stop = 1'b0;
    beat = 1'b0;
    expect_outputs("stop_idle", 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
    offer(6'd11, 6'd1);
    expect_outputs("stop_new_accept", 1'b0, 1'b1, 6'd11, 6'd1, 1'b0);
    // Abort this one too, this time with a fresh offer on the same edge.
    stop = 1'b1;
    bus.note_valid = 1'b1;
    bus.note_in    = 6'd44;
    bus.dur_in     = 6'd7;
    tick();
    expect_outputs("stop_over_playing", 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
    tick();                          // still stopping while offer held in IDLE
    stop = 1'b0;
    bus.note_valid = 1'b0;
    expect_outputs("stop_blocks_accept", 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
    // Reset in the middle of a note discards it with no done pulse.
    offer(6'd13, 6'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_outputs("reset_mid_note", 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int accepts;
    int dones;
    logic busy_prev;
    // Beat on the accepting edge is not counted.
    beat = 1'b1;
    offer(6'd33, 6'd1);
    beat = 1'b0;
    expect_outputs("coincident_beat", 1'b0, 1'b1, 6'd33, 6'd1, 1'b0);
    tick(3);
    expect_outputs("coincident_hold", 1'b0, 1'b1, 6'd33, 6'd1, 1'b0);
    beat_pulse();
    expect_outputs("coincident_done", 1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
    tick();
    // Hold valid high: one accept per IDLE -> PLAYING -> DONE loop of 3 cycles.
    accepts   = 0;
    dones     = 0;
    busy_prev = busy;
    bus.note_valid = 1'b1;
    bus.note_in    = 6'd40;
    bus.dur_in     = 6'd0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy && !busy_prev) accepts++;
      if (note_done) dones++;
      busy_prev = busy;
    end
    bus.note_valid = 1'b0;
    checks++;
    if (accepts !== 4) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d want 4", accepts);
    end
    checks++;
    if (dones !== 4) begin
      errors++;
      $display("FAIL b2b_dones: got %0d want 4", dones);
    end
    tick(3);
    expect_outputs("b2b_settle_idle", 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic test_max_dur();
    offer(6'd63, 6'd63);
    expect_outputs("max_accept", 1'b0, 1'b1, 6'd63, 6'd63, 1'b0);
    // A held beat counts one beat per cycle.
    beat = 1'b1;
    tick(62);
    beat = 1'b0;
    expect_outputs("max_one_left", 1'b0, 1'b1, 6'd63, 6'd1, 1'b0);
    beat_pulse();
    expect_outputs("max_done_no_wrap", 1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
    tick();
    expect_outputs("max_idle", 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    beat           = 1'b0;
    play           = 1'b1;
    stop           = 1'b0;
    bus.note_valid = 1'b0;
    bus.note_in    = '0;
    bus.dur_in     = '0;
    test_reset();
    test_basic();
    test_zero_dur();
    test_pause();
    test_stop();
    test_back_to_back();
    test_max_dur();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
